seq_alu: RTL and testbench

Parametrised, handshaked ALU that succeeds the combinational 64-bit datapath ALU. It keeps the existing 3-bit operation encoding and flag semantics, and adds three single-cycle shifts and an iterative unsigned multiply. Result and flags are registered behind a valid/ready output stage. It sits between operand fetch and writeback in the multicycle datapath; stalls propagate through the handshakes.

---
 rtl/seq_alu.sv | 127 ++++++++++++
 tb/tb_seq_alu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered flags, single-cycle ops and an iterative unsigned multiply
module seq_alu #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             illegal
);
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t r_state, w_next;
    logic [2*WIDTH-1:0] r_mcand, r_acc, w_prod;
    logic [WIDTH-1:0]   r_mplier, w_res;
    logic [SHW-1:0]     r_cnt, w_sh;
    logic [WIDTH:0]     w_add, w_sub;
    logic               w_accept, w_load, w_start, w_ovf, w_cry, w_ill, w_last;
    assign in_ready = rst_n & (r_state == IDLE) & (!out_valid | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_sh     = B[SHW-1:0];
    assign w_add    = {1'b0, A} + {1'b0, B};
    assign w_sub    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign w_prod   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last   = r_cnt == SHW'(WIDTH - 1);
    // state register; reset discards any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // next state, output-register load strobe and the value/flags to load
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_start = 1'b0;
        w_res   = '0;
        w_ovf   = 1'b0;
        w_cry   = 1'b0;
        w_ill   = 1'b0;
        if (r_state == MUL_BUSY) begin
            if (w_last) begin
                w_next = IDLE;
                w_load = 1'b1;
                w_res  = w_prod[WIDTH-1:0];
                w_ovf  = |w_prod[2*WIDTH-1:WIDTH];
            end
        end else if (w_accept) begin
            if (cntrl == 4'b1011) begin
                w_start = 1'b1;
                w_next  = MUL_BUSY;
            end else begin
                w_load = 1'b1;
                case (cntrl)
                    4'b0000: w_res = B;
                    4'b0010: begin
                        w_res = w_add[WIDTH-1:0];
                        w_cry = w_add[WIDTH];
                        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
                    end
                    4'b0011: begin
                        w_res = w_sub[WIDTH-1:0];
                        w_cry = w_sub[WIDTH];
                        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
                    end
                    4'b0100: w_res = A & B;
                    4'b0101: w_res = A | B;
                    4'b0110: w_res = A ^ B;
                    4'b1000: w_res = A << w_sh;
                    4'b1001: w_res = A >> w_sh;
                    4'b1010: w_res = $signed(A) >>> w_sh;
                    default: w_ill = 1'b1;
                endcase
            end
        end
    end
    // shift-and-add multiplier: one multiplier bit per cycle, WIDTH cycles total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == MUL_BUSY) begin
            r_acc    <= w_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHW'(1);
        end
    end
    // output stage: holds under backpressure, a same-edge drain and load keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= w_load ? 1'b1 : (out_ready ? 1'b0 : out_valid);
            if (w_load) begin
                result    <= w_res;
                negative  <= w_res[WIDTH-1];
                zero      <= w_res == '0;
                overflow  <= w_ovf;
                carry_out <= w_cry;
                illegal   <= w_ill;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu at WIDTH 64 plus an 8-bit multiply instance
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [63:0] A = '0, B = '0;
    logic [3:0]  cntrl = '0;
    logic        in_ready, out_valid, negative, zero, overflow, carry_out, illegal;
    logic [63:0] result;
    logic        v8 = 1'b0, rdy8, ov8, neg8, z8, o8, c8, il8;
    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic [3:0]  c8_op = '0;
    int n_checks = 0, n_errors = 0;
    int n;
    logic seen;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cntrl(cntrl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .negative(negative), .zero(zero), .overflow(overflow),
        .carry_out(carry_out), .illegal(illegal)
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .A(a8), .B(b8), .cntrl(c8_op), .out_valid(ov8), .out_ready(1'b1),
        .result(res8), .negative(neg8), .zero(z8), .overflow(o8),
        .carry_out(c8), .illegal(il8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        cntrl = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic flags(input string tag, input logic [63:0] r, input logic ng, input logic z,
                         input logic ov, input logic cy, input logic il);
        check({tag, " result"}, result, r);
        check({tag, " nzvci"}, {59'd0, negative, zero, overflow, carry_out, illegal},
              {59'd0, ng, z, ov, cy, il});
        check({tag, " valid"}, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", {63'd0, in_ready}, 64'd0);
        check("rst outs", {result[62:0], out_valid, negative, zero, overflow, carry_out, illegal},
              64'd0);
        rst_n = 1'b1;
        #1;
        check("release in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        issue(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        flags("add ovf", 64'h8000_0000_0000_0000, 1, 0, 1, 0, 0);
        cntrl = 4'b0011; A = 64'd5; B = 64'd5; in_valid = 1'b1;
        #1;
        check("b2b in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        flags("sub eq", 64'd0, 0, 1, 0, 1, 0);
        check("b2b in_ready2", {63'd0, in_ready}, 64'd1);
        A = 64'd0; B = 64'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flags("sub borrow", '1, 1, 0, 0, 0, 0);
        issue(4'b1010, 64'h8000_0000_0000_0000, 64'h43);
        flags("asr", 64'hF000_0000_0000_0000, 1, 0, 0, 0, 0);
        issue(4'b1001, 64'h8000_0000_0000_0000, 64'h43);
        flags("lsr", 64'h1000_0000_0000_0000, 0, 0, 0, 0, 0);
        issue(4'b1000, 64'h1234, 64'h4);
        flags("lsl", 64'h12340, 0, 0, 0, 0, 0);
        issue(4'b1000, 64'hABCD, 64'h40);
        flags("lsl0", 64'hABCD, 0, 0, 0, 0, 0);
        issue(4'b0000, 64'h1111, 64'h8000_0000_0000_00AA);
        flags("pass", 64'h8000_0000_0000_00AA, 1, 0, 0, 0, 0);
        issue(4'b0101, 64'hF0, 64'h0F);
        flags("or", 64'hFF, 0, 0, 0, 0, 0);
        issue(4'b0110, 64'hFF, 64'h0F);
        flags("xor", 64'hF0, 0, 0, 0, 0, 0);
        issue(4'b0010, '1, 64'd1);
        flags("add carry", 64'd0, 0, 1, 0, 1, 0);
        issue(4'b1011, 64'hFFFF_FFFF, 64'h1_0000_0001);
        check("mul in_ready", {63'd0, in_ready}, 64'd0);
        check("mul no valid", {63'd0, out_valid}, 64'd0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 200);
        check("mul latency", 64'(n), 64'd64);
        flags("mul", '1, 1, 0, 0, 0, 0);
        issue(4'b1011, 64'h8000_0000_0000_0000, 64'd2);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 200);
        flags("mul ovf", 64'd0, 0, 1, 1, 0, 0);
        issue(4'b1011, 64'd3, 64'd5);
        out_ready = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 200);
        check("bp latency", 64'(n), 64'd64);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            flags("bp hold", 64'd15, 0, 0, 0, 0, 0);
            check("bp in_ready", {63'd0, in_ready}, 64'd0);
        end
        cntrl = 4'b0100; A = 64'hF0; B = 64'h3C; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("drain in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flags("drain+and", 64'h30, 0, 0, 0, 0, 0);
        issue(4'b1011, 64'd3, 64'd5);
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", {63'd0, in_ready}, 64'd0);
        check("midrst outs", {result[62:0], out_valid, negative, zero, overflow, carry_out, illegal},
              64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst release rdy", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("no stale", {63'd0, seen}, 64'd0);
        check("no stale result", result, 64'd0);
        issue(4'b1111, 64'd5, 64'd7);
        flags("illegal", 64'd0, 0, 1, 0, 0, 1);
        issue(4'b0001, 64'h8000_0000_0000_0000, '1);
        flags("illegal1", 64'd0, 0, 1, 0, 0, 1);
        issue(4'b0100, 64'hFF, 64'h81);
        flags("and clr ill", 64'h81, 0, 0, 0, 0, 0);
        c8_op = 4'b1011; a8 = 8'h10; b8 = 8'h10; v8 = 1'b1;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ov8 && n < 100);
        check("mul8 latency", 64'(n), 64'd8);
        check("mul8 flags", {55'd0, res8, z8}, {55'd0, 8'h00, 1'b1});
        check("mul8 ovf", {62'd0, o8, c8}, 64'd2);
        c8_op = 4'b1011; a8 = 8'h0D; b8 = 8'h0B; v8 = 1'b1;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ov8 && n < 100);
        check("mul8b", {53'd0, res8, neg8, z8, o8}, {53'd0, 8'h8F, 1'b1, 1'b0, 1'b0});
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
